// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle of the sprite compositor: per-layer inputs plus the composited
// pixel and collision reporting outputs.
interface sprite_compositor_if #(
    parameter int NBR_LAYERS = 9,
    parameter int DATA_W     = 8
);
    localparam int SEL_W = $clog2(NBR_LAYERS);

    logic                         enb;
    logic                         frame_start;
    logic                         active;
    logic [NBR_LAYERS-1:0]        rden;
    logic [NBR_LAYERS*DATA_W-1:0] sprite_data;
    logic [NBR_LAYERS-1:0]        transp_en;
    logic [DATA_W-1:0]            pix_out;
    logic                         pix_valid;
    logic [SEL_W-1:0]             layer_sel;
    logic                         layer_hit;
    logic [NBR_LAYERS-1:0]        coll_live;
    logic [NBR_LAYERS-1:0]        coll_frame;
    logic                         coll_frame_valid;

    modport master (
        output enb, frame_start, active, rden, sprite_data, transp_en,
        input  pix_out, pix_valid, layer_sel, layer_hit,
               coll_live, coll_frame, coll_frame_valid
    );

    modport slave (
        input  enb, frame_start, active, rden, sprite_data, transp_en,
        output pix_out, pix_valid, layer_sel, layer_hit,
               coll_live, coll_frame, coll_frame_valid
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage priority compositor for stacked sprite layers, with per-frame
// accumulation of multi-layer overlaps (collisions).
module sprite_compositor #(
    parameter int                    NBR_LAYERS = 9,
    parameter int                    DATA_W     = 8,
    parameter logic [DATA_W-1:0]     TRANSP_KEY = 8'hE3,
    parameter logic [DATA_W-1:0]     BG_COLOR   = 8'h00,
    parameter logic [NBR_LAYERS-1:0] COLL_MASK  = {NBR_LAYERS{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_compositor_if.slave bus
);
    localparam int SEL_W = $clog2(NBR_LAYERS);
    localparam logic [NBR_LAYERS-1:0] ONE = {{(NBR_LAYERS-1){1'b0}}, 1'b1};

    // True when at least two bits are set: clearing the lowest set bit leaves something.
    function automatic logic multi_hot(input logic [NBR_LAYERS-1:0] v);
        return (v & (v - ONE)) != {NBR_LAYERS{1'b0}};
    endfunction

    logic [NBR_LAYERS-1:0] opaque_s;
    logic [DATA_W-1:0]     win_data_s;
    logic [SEL_W-1:0]      win_idx_s;

    logic [NBR_LAYERS-1:0] opaque_q;
    logic                  active_q;
    logic [DATA_W-1:0]     win_data_q;
    logic [SEL_W-1:0]      win_idx_q;

    logic [DATA_W-1:0]     pix_out_q;
    logic                  pix_valid_q;
    logic [SEL_W-1:0]      layer_sel_q;
    logic                  layer_hit_q;

    logic [NBR_LAYERS-1:0] coll_m_s;
    logic [NBR_LAYERS-1:0] coll_hit_s;
    logic [NBR_LAYERS-1:0] coll_live_d, coll_live_q;
    logic [NBR_LAYERS-1:0] coll_frame_d, coll_frame_q;
    logic                  coll_fv_d, coll_fv_q;

    // Opacity per layer and priority pick; scanning high to low lets layer 0 win last.
    always_comb begin
        opaque_s   = {NBR_LAYERS{1'b0}};
        win_data_s = {DATA_W{1'b0}};
        win_idx_s  = {SEL_W{1'b0}};
        for (int i = NBR_LAYERS - 1; i >= 0; i--) begin
            opaque_s[i] = bus.rden[i] & ~(bus.transp_en[i] &
                          (bus.sprite_data[DATA_W*i +: DATA_W] == TRANSP_KEY));
            win_data_s  = opaque_s[i] ? bus.sprite_data[DATA_W*i +: DATA_W] : win_data_s;
            win_idx_s   = opaque_s[i] ? SEL_W'(i) : win_idx_s;
        end
    end

    // Collision bookkeeping; a hit coinciding with frame_start lands in the snapshot only.
    always_comb begin
        coll_m_s     = opaque_q & COLL_MASK & {NBR_LAYERS{active_q}};
        coll_hit_s   = multi_hot(coll_m_s) ? coll_m_s : {NBR_LAYERS{1'b0}};
        coll_live_d  = coll_live_q;
        coll_frame_d = coll_frame_q;
        coll_fv_d    = 1'b0;
        if (bus.enb) begin
            if (bus.frame_start) begin
                coll_frame_d = coll_live_q | coll_hit_s;
                coll_live_d  = {NBR_LAYERS{1'b0}};
                coll_fv_d    = 1'b1;
            end else begin
                coll_live_d  = coll_live_q | coll_hit_s;
            end
        end else begin
            coll_live_d  = coll_live_q;
        end
    end

    // Stage 1 and stage 2 pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opaque_q    <= {NBR_LAYERS{1'b0}};
            active_q    <= 1'b0;
            win_data_q  <= {DATA_W{1'b0}};
            win_idx_q   <= {SEL_W{1'b0}};
            pix_out_q   <= {DATA_W{1'b0}};
            pix_valid_q <= 1'b0;
            layer_sel_q <= {SEL_W{1'b0}};
            layer_hit_q <= 1'b0;
        end else if (bus.enb) begin
            opaque_q    <= opaque_s;
            active_q    <= bus.active;
            win_data_q  <= win_data_s;
            win_idx_q   <= win_idx_s;
            pix_valid_q <= active_q;
            layer_hit_q <= |opaque_q;
            layer_sel_q <= (|opaque_q) ? win_idx_q : {SEL_W{1'b0}};
            pix_out_q   <= !active_q   ? {DATA_W{1'b0}} :
                           (|opaque_q) ? win_data_q : BG_COLOR;
        end else begin
            opaque_q    <= opaque_q;
            pix_out_q   <= pix_out_q;
        end
    end

    // Collision state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_live_q  <= {NBR_LAYERS{1'b0}};
            coll_frame_q <= {NBR_LAYERS{1'b0}};
            coll_fv_q    <= 1'b0;
        end else begin
            coll_live_q  <= coll_live_d;
            coll_frame_q <= coll_frame_d;
            coll_fv_q    <= coll_fv_d;
        end
    end

    assign bus.pix_out          = pix_out_q;
    assign bus.pix_valid        = pix_valid_q;
    assign bus.layer_sel        = layer_sel_q;
    assign bus.layer_hit        = layer_hit_q;
    assign bus.coll_live        = coll_live_q;
    assign bus.coll_frame       = coll_frame_q;
    assign bus.coll_frame_valid = coll_fv_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: two 4-layer instances share stimulus,
// one with full collision mask and one with mask 4'b0111.
module tb_sprite_compositor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_compositor_if #(.NBR_LAYERS(4), .DATA_W(8)) if_a ();
    sprite_compositor_if #(.NBR_LAYERS(4), .DATA_W(8)) if_m ();

    assign if_m.enb         = if_a.enb;
    assign if_m.frame_start = if_a.frame_start;
    assign if_m.active      = if_a.active;
    assign if_m.rden        = if_a.rden;
    assign if_m.sprite_data = if_a.sprite_data;
    assign if_m.transp_en   = if_a.transp_en;

    sprite_compositor #(.NBR_LAYERS(4), .DATA_W(8), .TRANSP_KEY(8'hE3),
                        .BG_COLOR(8'h49), .COLL_MASK(4'b1111))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    sprite_compositor #(.NBR_LAYERS(4), .DATA_W(8), .TRANSP_KEY(8'hE3),
                        .BG_COLOR(8'h49), .COLL_MASK(4'b0111))
        dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m.slave));

    typedef struct {
        int         due;
        logic [7:0] pix;
        logic       valid;
        logic [1:0] sel;
        logic       hit;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t last_exp;
    int   en_cnt = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enabled, non-reset edges: the unit of pipeline latency.
    always @(posedge clk) if (rst_n === 1'b1 && if_a.enb === 1'b1) en_cnt++;

    // Monitor: pop expected pixel when due; while stalled, outputs must not move.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == en_cnt) begin
            mon_e = sb_q.pop_front();
            chk("a.pix_out",   32'(if_a.pix_out),   32'(mon_e.pix));
            chk("a.pix_valid", 32'(if_a.pix_valid), 32'(mon_e.valid));
            chk("a.layer_sel", 32'(if_a.layer_sel), 32'(mon_e.sel));
            chk("a.layer_hit", 32'(if_a.layer_hit), 32'(mon_e.hit));
            chk("m.pix_out",   32'(if_m.pix_out),   32'(mon_e.pix));
            chk("m.layer_sel", 32'(if_m.layer_sel), 32'(mon_e.sel));
            last_exp = mon_e;
        end else if (rst_n === 1'b1 && if_a.enb === 1'b0) begin
            chk("frz.pix_out",   32'(if_a.pix_out),   32'(last_exp.pix));
            chk("frz.pix_valid", 32'(if_a.pix_valid), 32'(last_exp.valid));
            chk("frz.layer_sel", 32'(if_a.layer_sel), 32'(last_exp.sel));
        end
    end

    task automatic vec(input logic en, input logic fs, input logic act,
                       input logic [3:0] rd, input logic [3:0] tr,
                       input logic [7:0] d3, input logic [7:0] d2,
                       input logic [7:0] d1, input logic [7:0] d0,
                       input logic [7:0] ep, input logic ev,
                       input logic [1:0] es, input logic eh);
        exp_t e;
        if_a.enb         = en;
        if_a.frame_start = fs;
        if_a.active      = act;
        if_a.rden        = rd;
        if_a.transp_en   = tr;
        if_a.sprite_data = {d3, d2, d1, d0};
        if (en) begin
            e.due = en_cnt + 2; e.pix = ep; e.valid = ev; e.sel = es; e.hit = eh;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic fs);
        vec(1'b1, fs, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic cchk(input string tag, input logic [3:0] la, input logic [3:0] fa,
                        input logic fv, input logic [3:0] lm, input logic [3:0] fm);
        chk({tag, ".a.coll_live"},  32'(if_a.coll_live),        32'(la));
        chk({tag, ".a.coll_frame"}, 32'(if_a.coll_frame),       32'(fa));
        chk({tag, ".a.cfv"},        32'(if_a.coll_frame_valid), 32'(fv));
        chk({tag, ".m.coll_live"},  32'(if_m.coll_live),        32'(lm));
        chk({tag, ".m.coll_frame"}, 32'(if_m.coll_frame),       32'(fm));
        chk({tag, ".m.cfv"},        32'(if_m.coll_frame_valid), 32'(fv));
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, ".a.pix_out"},   32'(if_a.pix_out),   32'h0);
        chk({tag, ".a.pix_valid"}, 32'(if_a.pix_valid), 32'h0);
        chk({tag, ".a.layer_sel"}, 32'(if_a.layer_sel), 32'h0);
        chk({tag, ".a.layer_hit"}, 32'(if_a.layer_hit), 32'h0);
        cchk(tag, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_a.enb = 1'b0; if_a.frame_start = 1'b0; if_a.active = 1'b0;
        if_a.rden = 4'h0; if_a.transp_en = 4'h0; if_a.sprite_data = 32'h0;
        last_exp = '{0, 8'h00, 1'b0, 2'd0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        zero_chk("reset");
        rst_n = 1'b1;

        // Pixel priority, transparency, background, blanking
        vec(1'b1, 1'b0, 1'b1, 4'b1010, 4'b0000, 8'h11, 8'h00, 8'h22, 8'h00, 8'h22, 1'b1, 2'd1, 1'b1);
        vec(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0001, 8'h00, 8'h00, 8'h5A, 8'hE3, 8'h5A, 1'b1, 2'd1, 1'b1);
        vec(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'hE3, 8'hE3, 1'b1, 2'd0, 1'b1);
        vec(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 1'b1, 2'd0, 1'b0);
        vec(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00, 1'b0, 2'd0, 1'b1);
        vec(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'h49, 1'b1, 2'd0, 1'b0);
        vec(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hC0, 1'b1, 2'd2, 1'b1);
        vec(1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b1, 2'd3, 1'b1);
        cchk("acc", 4'b1011, 4'b0000, 1'b0, 4'b0011, 4'b0000);
        idle(1'b1);
        cchk("snap1", 4'b0000, 4'b1011, 1'b1, 4'b0000, 4'b0011);
        idle(1'b0);
        cchk("snap1_end", 4'b0000, 4'b1011, 1'b0, 4'b0000, 4'b0011);

        // Layers 2 and 3 overlap, then a frame boundary
        vec(1'b1, 1'b0, 1'b1, 4'b1100, 4'b0000, 8'h11, 8'h22, 8'h00, 8'h00, 8'h22, 1'b1, 2'd2, 1'b1);
        idle(1'b0);
        cchk("c23", 4'b1100, 4'b1011, 1'b0, 4'b0000, 4'b0011);
        idle(1'b1);
        cchk("snap2", 4'b0000, 4'b1100, 1'b1, 4'b0000, 4'b0000);
        idle(1'b0);
        cchk("snap2_end", 4'b0000, 4'b1100, 1'b0, 4'b0000, 4'b0000);

        // Layers 0 and 2 overlap: counted by both masks
        vec(1'b1, 1'b0, 1'b1, 4'b0101, 4'b0000, 8'h00, 8'h33, 8'h00, 8'h44, 8'h44, 1'b1, 2'd0, 1'b1);
        idle(1'b0);
        cchk("c02", 4'b0101, 4'b1100, 1'b0, 4'b0101, 4'b0000);

        // Hit coinciding with frame_start, then back-to-back frame_start
        vec(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000, 8'h00, 8'h00, 8'h01, 8'h02, 8'h02, 1'b1, 2'd0, 1'b1);
        idle(1'b1);
        cchk("snap3", 4'b0000, 4'b0111, 1'b1, 4'b0000, 4'b0111);
        idle(1'b1);
        cchk("snap4", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        idle(1'b0);
        cchk("snap4_end", 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);

        // Stall for 5 cycles with a frame_start and garbage on the inputs
        vec(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000, 8'h00, 8'h00, 8'h66, 8'h77, 8'h77, 1'b1, 2'd0, 1'b1);
        vec(1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h5C, 1'b1, 2'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            vec(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 1'b0, 2'd0, 1'b0);
            cchk("stall", 4'b0011, 4'b0000, 1'b0, 4'b0011, 4'b0000);
        end
        idle(1'b0);
        cchk("resume", 4'b0011, 4'b0000, 1'b0, 4'b0011, 4'b0000);

        // Reset beats enb/frame_start and drops live collisions silently
        sb_q.delete();
        rst_n = 1'b0;
        if_a.enb = 1'b1; if_a.frame_start = 1'b1; if_a.active = 1'b1; if_a.rden = 4'b0011;
        @(posedge clk); #1;
        zero_chk("midrst");
        rst_n = 1'b1;
        idle(1'b0);
        cchk("post_rst", 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        idle(1'b0);
        idle(1'b0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        chk("drain", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
